pwm_duty_sequencer: RTL and testbench

Controller that sequences the duty-cycle register of the tt_um_pwm_gen PWM core. It accepts ramp commands (target duty, step size, update interval) over a valid/ready handshake. It moves the duty toward the target in saturating steps and applies each update only at a PWM period boundary, so the output is glitch-free. It sits between the ui_in/uio_in command decode and the PWM counter/comparator.

---
 rtl/pwm_seq_pkg.sv | 27 ++
 rtl/pwm_interval_counter.sv | 26 ++
 rtl/pwm_duty_sequencer.sv | 92 +++++++++
 tb/tb_pwm_duty_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// rtl/pwm_seq_pkg.sv - shared types, defaults and saturating step helper for the duty sequencer
package pwm_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } seq_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_IVL_W = 8;

  // Operands are zero-extended by the caller; the extra top bit keeps cur+step from wrapping.
  function automatic logic [31:0] sat_step(input logic [31:0] cur,
                                           input logic [31:0] tgt,
                                           input logic [31:0] step);
    logic [32:0] sum;
    logic [32:0] gap;
    sum = {1'b0, cur} + {1'b0, step};
    gap = {1'b0, cur} - {1'b0, tgt};
    if (tgt > cur) begin
      sat_step = (sum >= {1'b0, tgt}) ? tgt : sum[31:0];
    end else begin
      sat_step = ({1'b0, step} >= gap) ? tgt : (cur - step);
    end
  endfunction

endpackage

// File: rtl/pwm_interval_counter.sv
// rtl/pwm_interval_counter.sv - counts period_end pulses and ticks on every (interval+1)th one
module pwm_interval_counter #(
  parameter int IVL_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             period_end,
  input  logic [IVL_W-1:0] interval,
  output logic             tick
);

  logic [IVL_W-1:0] cnt;

  assign tick = enable && period_end && (cnt == interval);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && period_end) begin
      cnt <= (cnt == interval) ? '0 : cnt + IVL_W'(1);
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - ramps the PWM duty register toward a target at period boundaries
module pwm_duty_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IVL_W = DEF_IVL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic [WIDTH-1:0] cmd_step,
  input  logic [IVL_W-1:0] cmd_interval,
  input  logic             period_end,
  input  logic             abort,
  output logic [WIDTH-1:0] duty_out,
  output logic             duty_load,
  output logic             busy,
  output logic             done
);

  seq_state_t       state;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] step_q;
  logic [IVL_W-1:0] ivl_q;
  logic [WIDTH-1:0] next_duty;
  logic             accept;
  logic             tick;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_ready && cmd_valid && !abort;
  assign next_duty = WIDTH'(sat_step(32'(duty_out), 32'(tgt_q), 32'(step_q)));

  // Counting only runs in WAIT, so a period_end in the accept cycle is never counted.
  pwm_interval_counter #(.IVL_W(IVL_W)) u_ivl_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept || abort),
    .enable     ((state == WAIT) && !abort),
    .period_end (period_end),
    .interval   (ivl_q),
    .tick       (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      duty_out  <= '0;
      duty_load <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tgt_q     <= '0;
      step_q    <= '0;
      ivl_q     <= '0;
    end else begin
      duty_load <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tgt_q  <= cmd_target;
            step_q <= (cmd_step == '0) ? WIDTH'(1) : cmd_step;
            ivl_q  <= cmd_interval;
            if (cmd_target != duty_out) begin
              state <= WAIT;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            duty_out  <= next_duty;
            duty_load <= 1'b1;
            if (next_duty == tgt_q) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb/tb_pwm_duty_sequencer.sv - randomized and directed bench against a queue-based duty ramp model
module tb_pwm_duty_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       period_end = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cmd_target = '0;
  logic [7:0] cmd_step = '0;
  logic [7:0] cmd_interval = '0;
  logic       cmd_ready;
  logic [7:0] duty_out;
  logic       duty_load;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;
  int loads = 0;

  int m_duty = 0;
  bit m_busy = 1'b0;
  int m_ivl = 0;
  int m_pe = 0;
  int m_q[$];
  bit exp_load = 1'b0;
  bit exp_done = 1'b0;

  pwm_duty_sequencer #(.WIDTH(8), .IVL_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_target   (cmd_target),
    .cmd_step     (cmd_step),
    .cmd_interval (cmd_interval),
    .period_end   (period_end),
    .abort        (abort),
    .duty_out     (duty_out),
    .duty_load    (duty_load),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Whole ramp is precomputed as a list of duty values; each (ivl+1)th period_end pops one.
  task automatic model_step();
    int t;
    int s;
    int cur;
    exp_load = 1'b0;
    exp_done = 1'b0;
    if (rst) begin
      m_duty = 0;
      m_busy = 1'b0;
      m_q.delete();
    end else if (abort) begin
      m_busy = 1'b0;
      m_q.delete();
    end else if (!m_busy) begin
      if (cmd_valid) begin
        t = int'(cmd_target);
        s = (cmd_step == 8'd0) ? 1 : int'(cmd_step);
        if (t == m_duty) begin
          exp_done = 1'b1;
        end else begin
          cur = m_duty;
          while (cur != t) begin
            if (t > cur) cur = (cur + s > t) ? t : cur + s;
            else         cur = (cur - s < t) ? t : cur - s;
            m_q.push_back(cur);
          end
          m_busy = 1'b1;
          m_pe   = 0;
          m_ivl  = int'(cmd_interval);
        end
      end
    end else if (period_end) begin
      m_pe++;
      if (m_pe % (m_ivl + 1) == 0) begin
        m_duty   = m_q.pop_front();
        exp_load = 1'b1;
        if (m_q.size() == 0) begin
          exp_done = 1'b1;
          m_busy   = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_eq("duty_out", 32'(duty_out), 32'(m_duty));
    check_eq("duty_load", 32'(duty_load), 32'(exp_load));
    check_eq("done", 32'(done), 32'(exp_done));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
    if (duty_load === 1'b1) loads++;
    cmd_valid  = 1'b0;
    period_end = 1'b0;
    abort      = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic send(input int t, input int s, input int i);
    cmd_target   = 8'(t);
    cmd_step     = 8'(s);
    cmd_interval = 8'(i);
    cmd_valid    = 1'b1;
    cycle();
  endtask

  task automatic ramp_until(input int stop_duty, input int budget);
    int k;
    k = 0;
    while (m_busy && m_duty != stop_duty && k < budget) begin
      period_end = (k % 16 == 15);
      cycle();
      k++;
    end
    if (k >= budget) begin
      checks++;
      failures++;
      $display("FAIL ramp_budget: got %0d cycles expected under %0d", k, budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    do_reset();

    loads = 0;
    send(100, 30, 0);
    ramp_until(-1, 400);
    check_eq("up_final", 32'(duty_out), 32'd100);
    check_eq("up_loads", 32'(loads), 32'd4);

    loads = 0;
    send(10, 50, 2);
    ramp_until(-1, 800);
    check_eq("down_final", 32'(duty_out), 32'd10);
    check_eq("down_loads", 32'(loads), 32'd2);

    do_reset();
    loads = 0;
    send(255, 200, 0);
    ramp_until(-1, 400);
    check_eq("top_final", 32'(duty_out), 32'd255);
    check_eq("top_loads", 32'(loads), 32'd2);
    loads = 0;
    send(255, 7, 0);
    check_eq("same_done", 32'(done), 32'd1);
    check_eq("same_loads", 32'(loads), 32'd0);

    do_reset();
    send(200, 30, 0);
    ramp_until(30, 400);
    send(5, 1, 0);
    check_eq("drop_ready", 32'(cmd_ready), 32'd0);
    ramp_until(60, 400);
    abort      = 1'b1;
    period_end = 1'b1;
    cycle();
    check_eq("abort_duty", 32'(duty_out), 32'd60);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_ready", 32'(cmd_ready), 32'd1);

    send(200, 30, 0);
    ramp_until(90, 400);
    rst = 1'b1;
    cycle();
    check_eq("rst_duty", 32'(duty_out), 32'd0);
    loads = 0;
    send(3, 0, 0);
    ramp_until(-1, 400);
    check_eq("step0_final", 32'(duty_out), 32'd3);
    check_eq("step0_loads", 32'(loads), 32'd3);

    for (int n = 0; n < 4000; n++) begin
      period_end   = ($urandom_range(0, 3) == 0);
      cmd_valid    = ($urandom_range(0, 2) == 0);
      cmd_target   = 8'($urandom_range(0, 255));
      cmd_step     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      cmd_interval = 8'($urandom_range(0, 3));
      abort        = ($urandom_range(0, 63) == 0);
      rst          = ($urandom_range(0, 255) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
